rec_arbiter: RTL and testbench

Shares one recursive-computation engine (start/done sequenced datapath with its own control FSM) between two requesters. Grants the engine round-robin, latches the winner's operand N, issues a one-cycle start, waits for done, and returns the result to the winner with a one-cycle acknowledge. An optional watchdog aborts jobs the engine never finishes.

---
 rtl/rec_arbiter.sv | 111 +++++++++++
 tb/tb_rec_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rec_arbiter.sv
// Round-robin arbiter sharing one start/done recursive engine between two clients.
// Optional watchdog on the WAIT state is compiled in with `define REC_ARB_TIMEOUT_EN.
module rec_arbiter #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          res,
    input  logic          req0,
    input  logic          req1,
    input  logic [DW-1:0] op0,
    input  logic [DW-1:0] op1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic          busy,
    output logic          eng_start,
    output logic [DW-1:0] eng_n,
    input  logic          eng_done,
    input  logic [DW-1:0] eng_result
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic   ptr;
    logic   winner;
    logic   grant_id;
    logic   any_req;
    logic   timeout_hit;
    logic   finish;

    assign any_req = req0 | req1;
    assign finish  = (state == WAIT) && (eng_done || timeout_hit);

    // Sole requester wins outright; under contention the pointer decides.
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
        grant_id = req1;
        if (req0 && req1) begin
            grant_id = ptr;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = WAIT;
            WAIT:    if (eng_done || timeout_hit) state_nxt = DELIVER;
            DELIVER: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!res) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            winner   <= 1'b0;
            eng_n    <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) begin
                winner <= grant_id;
                ptr    <= ~grant_id;
                eng_n  <= grant_id ? op1 : op0;
            end
            // A done in the final watchdog cycle takes precedence over the timeout.
            if (finish) begin
                rsp_data <= eng_done ? eng_result : '0;
                rsp_err  <= ~eng_done;
            end
        end
    end

`ifdef REC_ARB_TIMEOUT_EN
    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

    logic [15:0] wait_cnt;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            wait_cnt <= '0;
        end else if (state == LAUNCH) begin
            wait_cnt <= '0;
        end else if (state == WAIT && !eng_done) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    assign timeout_hit = (state == WAIT) && (wait_cnt == LAST_WAIT);
`else
    assign timeout_hit = 1'b0;
`endif

    assign busy      = (state != IDLE);
    assign eng_start = (state == LAUNCH);
    assign ack0      = (state == DELIVER) && !winner;
    assign ack1      = (state == DELIVER) &&  winner;

endmodule

// File: tb/tb_rec_arbiter.sv
// Self-checking bench for rec_arbiter: engine model, client drivers, and a
// scoreboard monitor that checks grant order and responses against a reference model.
module tb_rec_arbiter;

    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          res;
    logic          req0, req1;
    logic [DW-1:0] op0, op1;
    logic          ack0, ack1;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          busy;
    logic          eng_start;
    logic [DW-1:0] eng_n;
    logic          eng_done;
    logic [DW-1:0] eng_result;

    rec_arbiter #(.DW(DW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .res        (res),
        .req0       (req0),
        .req1       (req1),
        .op0        (op0),
        .op1        (op1),
        .ack0       (ack0),
        .ack1       (ack1),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .eng_start  (eng_start),
        .eng_n      (eng_n),
        .eng_done   (eng_done),
        .eng_result (eng_result)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard state: expected {err, data} per client, expected winner order.
    logic [DW:0]   exp_q0[$];
    logic [DW:0]   exp_q1[$];
    int            win_q[$];
    logic [DW-1:0] en_log[$];
    logic [DW-1:0] cur_op[2];
    int            last_win;
    int            n_start = 0, n_ack0 = 0, n_ack1 = 0;

    // Engine model controls.
    logic          eng_tie, eng_hang, eng_force, eng_rand;
    logic [DW-1:0] eng_force_val;
    int            eng_delay;
    logic          e_pend = 1'b0;
    int            e_cnt = 0;
    logic [DW-1:0] e_job = '0;
    logic          e_start_prev = 1'b0;

    function automatic logic [DW-1:0] eng_fn(input logic [DW-1:0] n);
        return n * 32'h9E37_79B1 + 32'd1;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Engine: result f(n) after a programmable number of WAIT cycles; junk result otherwise.
    initial begin : engine
        eng_done   = 1'b0;
        eng_result = '0;
        forever begin
            @(posedge clk);
            #2;
            eng_done   = 1'b0;
            eng_result = DW'($urandom);
            if (!res) e_pend = 1'b0;
            if (eng_tie) begin
                eng_done   = 1'b1;
                e_pend     = 1'b0;
                if (e_start_prev) eng_result = eng_fn(eng_n);
            end else begin
                if (e_pend) begin
                    e_cnt--;
                    if (e_cnt == 0) begin
                        eng_done   = 1'b1;
                        eng_result = eng_force ? eng_force_val : eng_fn(e_job);
                        e_pend     = 1'b0;
                    end
                end
                if (eng_start && !eng_hang) begin
                    e_pend = 1'b1;
                    e_cnt  = eng_rand ? int'($urandom_range(1, TO)) : eng_delay;
                    e_job  = eng_n;
                end
            end
            e_start_prev = eng_start;
        end
    end

    // Monitor: predicts each grant from the requests seen in IDLE, checks every ack.
    initial begin : monitor
        logic [1:0]  prev_req;
        logic [DW:0] last_rsp;
        int          w;
        int          c;
        prev_req = 2'b00;
        last_rsp = '0;
        forever begin
            @(negedge clk);
            if (res) begin
                if (eng_start) begin
                    n_start++;
                    check("grant_had_req", prev_req != 2'b00, 1);
                    w = (prev_req == 2'b11) ? 1 - last_win : int'(prev_req[1]);
                    last_win = w;
                    win_q.push_back(w);
                    en_log.push_back(eng_n);
                    check("launch_eng_n", eng_n, cur_op[w]);
                    check("launch_busy", busy, 1);
                end
                if (ack0 || ack1) begin
                    c = ack1 ? 1 : 0;
                    if (c == 0) n_ack0++; else n_ack1++;
                    check("ack_exclusive", ack0 & ack1, 0);
                    check("deliver_busy", busy, 1);
                    check("ack_has_grant", win_q.size() > 0, 1);
                    if (win_q.size() > 0) check("ack_client", c, win_q.pop_front());
                    if (c == 0) begin
                        check("exp0_pending", exp_q0.size() > 0, 1);
                        if (exp_q0.size() > 0) check("rsp0", {rsp_err, rsp_data}, exp_q0.pop_front());
                    end else begin
                        check("exp1_pending", exp_q1.size() > 0, 1);
                        if (exp_q1.size() > 0) check("rsp1", {rsp_err, rsp_data}, exp_q1.pop_front());
                    end
                end else begin
                    check("rsp_hold", {rsp_err, rsp_data}, last_rsp);
                end
            end
            prev_req = {req1, req0};
            last_rsp = {rsp_err, rsp_data};
        end
    end

    // One client job: push expectation, hold req/op until ack, drop req at the edge sampling ack.
    task automatic client_job(input int c, input logic [DW-1:0] op, input logic [DW:0] exp, output int cyc);
        logic got;
        cur_op[c] = op;
        if (c == 0) begin exp_q0.push_back(exp); op0 = op; req0 = 1'b1; end
        else        begin exp_q1.push_back(exp); op1 = op; req1 = 1'b1; end
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            got = (c == 0) ? ack0 : ack1;
        end
        check("ack_seen", got, 1);
        @(posedge clk);
        #1;
        if (c == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    task automatic rand_client(input int c, input int jobs);
        logic [DW-1:0] op;
        int            cy;
        for (int i = 0; i < jobs; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            op = DW'($urandom);
            client_job(c, op, {1'b0, eng_fn(op)}, cy);
        end
    endtask

    task automatic flush_model();
        win_q.delete();
        exp_q0.delete();
        exp_q1.delete();
        en_log.delete();
        last_win = 1;
    endtask

    task automatic do_reset();
        res  = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        flush_model();
        repeat (2) begin @(posedge clk); #1; end
        check("reset_ctrl", {ack0, ack1, busy, eng_start, rsp_err}, 0);
        check("reset_data", {eng_n, rsp_data}, 0);
        res = 1'b1;
    endtask

    initial begin : watchdog_timer
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1, "global timeout");
    end

    initial begin : main
        int            cy0, cy1, s0, a1;
        logic [DW-1:0] tmp;
        res = 1'b0; req0 = 1'b0; req1 = 1'b0; op0 = '0; op1 = '0;
        eng_tie = 1'b0; eng_hang = 1'b0; eng_force = 1'b0; eng_rand = 1'b0;
        eng_force_val = '0; eng_delay = 1;
        last_win = 1;
        @(posedge clk);
        #1;
        do_reset();

        // Single job, engine answers two cycles after start.
        eng_delay = 2; eng_force = 1'b1; eng_force_val = DW'(32'h1234);
        s0 = n_start; a1 = n_ack1;
        client_job(0, DW'(5), {1'b0, DW'(32'h1234)}, cy0);
        check("single_starts", n_start - s0, 1);
        check("single_no_ack1", n_ack1 - a1, 0);
        check("single_eng_n", eng_n, 5);
        check("idle_not_busy", busy, 0);
        eng_force = 1'b0;

        // Contention from reset: strict alternation 0,1,0,1.
        do_reset();
        fork
            begin for (int i = 0; i < 2; i++) client_job(0, DW'(3), {1'b0, eng_fn(DW'(3))}, cy0); end
            begin for (int i = 0; i < 2; i++) client_job(1, DW'(7), {1'b0, eng_fn(DW'(7))}, cy1); end
        join
        check("contention_jobs", en_log.size(), 4);
        if (en_log.size() == 4) begin
            check("contention_n0", en_log[0], 3);
            check("contention_n1", en_log[1], 7);
            check("contention_n2", en_log[2], 3);
            check("contention_n3", en_log[3], 7);
        end

        // Minimum latency with eng_done tied high; stray done in IDLE/LAUNCH must not capture.
        eng_tie = 1'b1;
        tmp = DW'($urandom);
        client_job(0, tmp, {1'b0, eng_fn(tmp)}, cy0);
        check("min_latency0", cy0, 3);
        repeat (3) begin @(posedge clk); #1; end
        check("stray_done_hold", rsp_data, eng_fn(tmp));
        tmp = DW'($urandom);
        client_job(1, tmp, {1'b0, eng_fn(tmp)}, cy1);
        check("min_latency1", cy1, 3);
        eng_tie = 1'b0;
        @(posedge clk);
        #1;

        // Operand change during WAIT must not reach eng_n.
        eng_delay = 4;
        cur_op[0] = DW'(9);
        exp_q0.push_back({1'b0, eng_fn(DW'(9))});
        op0 = DW'(9); req0 = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        op0 = DW'(2);
        repeat (2) begin @(posedge clk); #1; check("eng_n_hold_wait", eng_n, 9); end
        cy0 = 0;
        while (!ack0 && cy0 < 20) begin @(posedge clk); #1; cy0++; end
        check("opstab_ack", ack0, 1);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("eng_n_hold_idle", eng_n, 9);
        client_job(0, DW'(2), {1'b0, eng_fn(DW'(2))}, cy0);

`ifdef REC_ARB_TIMEOUT_EN
        // Watchdog: no done -> error after TIMEOUT WAIT cycles; done on the last cycle wins.
        eng_hang = 1'b1;
        client_job(1, DW'(42), {1'b1, {DW{1'b0}}}, cy1);
        check("timeout_latency", cy1, 2 + TO);
        eng_hang = 1'b0;
        eng_delay = TO;
        client_job(0, DW'(77), {1'b0, eng_fn(DW'(77))}, cy0);
        check("done_last_wait_latency", cy0, 2 + TO);
`endif

        // Reset during WAIT of client 1: no ack, pointer back to client 0.
        eng_hang = 1'b1;
        cur_op[1] = DW'(11);
        op1 = DW'(11); req1 = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("midjob_busy", busy, 1);
        s0 = n_ack0 + n_ack1;
        res = 1'b0;
        #1;
        check("midjob_reset_ctrl", {ack0, ack1, busy, eng_start, rsp_err}, 0);
        check("midjob_reset_data", {eng_n, rsp_data}, 0);
        req1 = 1'b0;
        flush_model();
        eng_hang = 1'b0; eng_delay = 1;
        @(posedge clk);
        #1;
        check("midjob_no_ack", n_ack0 + n_ack1, s0);
        res = 1'b1;
        fork
            client_job(0, DW'(21), {1'b0, eng_fn(DW'(21))}, cy0);
            client_job(1, DW'(11), {1'b0, eng_fn(DW'(11))}, cy1);
        join
        check("post_reset_first", en_log.size() > 0 ? en_log[0] : '1, 21);

        // Randomized traffic from both clients.
        eng_rand = 1'b1;
        fork
            rand_client(0, 15);
            rand_client(1, 15);
        join
        repeat (5) begin @(posedge clk); #1; end
        check("drain_exp0", exp_q0.size(), 0);
        check("drain_exp1", exp_q1.size(), 0);
        check("drain_grants", win_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
